// File: rtl/dec_fault_pkg.sv
// Shared constants for the fault-injected 4-to-16 decoder.
// Site codes above the output lines select the half-decoder enables.
package dec_fault_pkg;
    localparam int SEL_W      = 4;
    localparam int OUT_W      = 16;
    localparam int SITE_EN_LO = 16;
    localparam int SITE_EN_HI = 17;
endpackage

// File: rtl/dec_3x8_en.sv
// 3-to-8 one-hot decoder with enable; purely combinational, zero latency.
// No flow control: output follows inputs continuously.
module dec_3x8_en (
    input  logic [2:0] sel,
    input  logic       en,
    output logic [7:0] y
);
    always_comb begin
        y = '0;
        if (en) begin
            y[sel] = 1'b1;
        end
    end
endmodule

// File: rtl/dec_4x16_w_fault_1.sv
// Registered 4-to-16 decoder (two 3-to-8 halves) with one parameter-selected stuck-at fault.
// Latency 1 cycle, no backpressure; fault_flag marks a registered output that is not one-hot.
module dec_4x16_w_fault_1
    import dec_fault_pkg::*;
#(
    parameter int FAULT_EN   = 1,
    parameter int FAULT_SITE = 17,
    parameter int FAULT_VAL  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             X,
    input  logic             Y,
    input  logic             Z,
    input  logic             W,
    output logic [OUT_W-1:0] D,
    output logic             fault_flag
);
    localparam logic STUCK = (FAULT_VAL != 0);

    logic             en_lo;
    logic             en_hi;
    logic [7:0]       y_lo;
    logic [7:0]       y_hi;
    logic [OUT_W-1:0] d_d;
    logic [OUT_W-1:0] d_q;
    logic             fault_flag_d;
    logic             fault_flag_q;
    logic [4:0]       ones;

    always_comb begin
        en_lo = ~X;
        en_hi = X;
        if (FAULT_EN != 0 && FAULT_SITE == SITE_EN_LO) begin
            en_lo = STUCK;
        end
        if (FAULT_EN != 0 && FAULT_SITE == SITE_EN_HI) begin
            en_hi = STUCK;
        end
    end

    dec_3x8_en u_dec_lo (
        .sel ({Y, Z, W}),
        .en  (en_lo),
        .y   (y_lo)
    );

    dec_3x8_en u_dec_hi (
        .sel ({Y, Z, W}),
        .en  (en_hi),
        .y   (y_hi)
    );

    // Output-line faults override the decode; sites beyond 17 match nothing here.
    always_comb begin
        d_d  = {y_hi, y_lo};
        ones = '0;
        for (int i = 0; i < OUT_W; i++) begin
            if (FAULT_EN != 0 && FAULT_SITE == i) begin
                d_d[i] = STUCK;
            end
        end
        for (int i = 0; i < OUT_W; i++) begin
            ones = ones + 5'(d_d[i]);
        end
        fault_flag_d = (ones != 5'd1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_q          <= '0;
            fault_flag_q <= 1'b0;
        end else begin
            d_q          <= d_d;
            fault_flag_q <= fault_flag_d;
        end
    end

    assign D          = d_q;
    assign fault_flag = fault_flag_q;
endmodule

// File: tb/tb_dec_4x16_w_fault_1.sv
// Bench: eight decoder instances with different fault configurations share one stimulus stream.
module tb_dec_4x16_w_fault_1;
    localparam int N = 8;
    // Per-instance configuration, index 0 is the default build.
    localparam logic [N-1:0]      EN_TAB   = 8'b1111_1101;
    localparam logic [N-1:0]      VAL_TAB  = 8'b1001_1100;
    localparam logic [N-1:0][4:0] SITE_TAB = {5'd20, 5'd16, 5'd3, 5'd17,
                                              5'd16, 5'd5, 5'd17, 5'd17};

    logic        clk = 1'b0;
    logic        rst;
    logic        X, Y, Z, W;
    logic [15:0] d_obs [N];
    logic        f_obs [N];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        dec_4x16_w_fault_1 #(
            .FAULT_EN   (int'(EN_TAB[g])),
            .FAULT_SITE (int'(SITE_TAB[g])),
            .FAULT_VAL  (int'(VAL_TAB[g]))
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .X          (X),
            .Y          (Y),
            .Z          (Z),
            .W          (W),
            .D          (d_obs[g]),
            .fault_flag (f_obs[g])
        );
    end

    // Reference: an ideal decoder is one bit at position S; each half only lights
    // when its enable holds, and a forced enable lights position S mod 8 in that half.
    function automatic logic [16:0] model(input int k, input int s);
        int          en, site, val;
        int          lo_on, hi_on;
        logic [15:0] d;
        en   = int'(EN_TAB[k]);
        site = int'(SITE_TAB[k]);
        val  = int'(VAL_TAB[k]);
        lo_on = (s < 8);
        hi_on = (s >= 8);
        if (en == 1 && site == 16) lo_on = val;
        if (en == 1 && site == 17) hi_on = val;
        d = 16'h0000;
        if (lo_on == 1) d = d | (16'h0001 << (s % 8));
        if (hi_on == 1) d = d | (16'h0100 << (s % 8));
        if (en == 1 && site < 16) begin
            if (val == 1) d = d | (16'h0001 << site);
            else          d = d & ~(16'h0001 << site);
        end
        return {($countones(d) != 1), d};
    endfunction

    task automatic check_all(input string tag, input int s, input bit in_rst);
        logic [16:0] exp;
        for (int k = 0; k < N; k++) begin
            exp = in_rst ? 17'h0 : model(k, s);
            checks++;
            assert ({f_obs[k], d_obs[k]} === exp) else begin
                errors++;
                $error("FAIL %s inst=%0d S=%0d observed flag/D=%0b/%h expected %0b/%h",
                       tag, k, s, f_obs[k], d_obs[k], exp[16], exp[15:0]);
            end
        end
    endtask

    // Drive on the falling edge, then sample 1 time unit after the rising edge.
    task automatic step(input string tag, input int s, input bit r);
        @(negedge clk);
        rst = r;
        {X, Y, Z, W} = 4'(s);
        @(posedge clk);
        #1;
        check_all(tag, s, r);
    endtask

    task automatic expect_one(input string tag, input int k, input logic [15:0] d_exp,
                              input logic f_exp);
        checks++;
        assert (d_obs[k] === d_exp && f_obs[k] === f_exp) else begin
            errors++;
            $error("FAIL %s inst=%0d observed D=%h flag=%0b expected D=%h flag=%0b",
                   tag, k, d_obs[k], f_obs[k], d_exp, f_exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        {X, Y, Z, W} = 4'b0000;

        step("reset0", 0, 1'b1);
        step("reset1", 0, 1'b1);
        expect_one("reset_d", 0, 16'h0000, 1'b0);
        step("release", 0, 1'b0);
        expect_one("release_d", 0, 16'h0001, 1'b0);

        for (int s = 0; s < 16; s++) begin
            step("sweep", s, 1'b0);
        end

        step("ideal_1010", 10, 1'b0);
        expect_one("ideal_1010_d", 1, 16'h0400, 1'b0);
        expect_one("hi_stuck0_1010", 0, 16'h0000, 1'b1);

        step("site5_s0", 0, 1'b0);
        expect_one("site5_s0_d", 2, 16'h0021, 1'b1);
        step("site5_s5", 5, 1'b0);
        expect_one("site5_s5_d", 2, 16'h0020, 1'b0);

        step("enlo1_1011", 11, 1'b0);
        expect_one("enlo1_1011_d", 3, 16'h0808, 1'b1);
        step("enlo1_0011", 3, 1'b0);
        expect_one("enlo1_0011_d", 3, 16'h0008, 1'b0);

        step("pre_midrst", 15, 1'b0);
        step("midrst", 15, 1'b1);
        expect_one("midrst_d", 1, 16'h0000, 1'b0);
        step("post_midrst", 15, 1'b0);
        expect_one("post_midrst_d", 1, 16'h8000, 1'b0);

        for (int i = 0; i < 300; i++) begin
            step("random", int'($urandom_range(15, 0)), ($urandom_range(15, 0) == 0));
        end

        // Inputs toggled between edges must not disturb the registered outputs.
        step("hold_base", 6, 1'b0);
        @(negedge clk);
        {X, Y, Z, W} = 4'd9;
        #2;
        {X, Y, Z, W} = 4'd6;
        @(posedge clk);
        #1;
        check_all("glitch", 6, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dec_4x16_w_fault_1.md
# dec_4x16_w_fault_1

Registered 4-to-16 line decoder built from two 3-to-8 decoders, with one deliberately injected, parameter-selected fault. It serves as a fault-model device under test in the decoder study set: fault-free behaviour is the reference, and the injected fault's effect must appear on the outputs exactly as specified. A one-hot checker flag reports when the registered output is not a valid one-hot code.

## Interface
Parameters:
- FAULT_EN, default 1: 1 applies the fault; 0 gives an ideal decoder.
- FAULT_SITE, default 17: 0–15 selects output line D[n]; 16 selects the low-half decoder enable; 17 selects the high-half decoder enable.
- FAULT_VAL, default 0: stuck-at value (0 or 1) forced onto the selected site.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous and active-high.
- X  in  1  select bit 3 (MSB); chooses the decoder half.
- Y  in  1  select bit 2.
- Z  in  1  select bit 1.
- W  in  1  select bit 0 (LSB).
- D  out  16  registered decoded outputs, active-high.
- fault_flag  out  1  registered; 1 when D is not exactly one-hot.

## Operation
- Select code: S = {X,Y,Z,W}, range 0–15.
- Low 3-to-8 decoder: enable en_lo = ~X; its outputs drive D[7:0], with line {Y,Z,W} high when enabled.
- High 3-to-8 decoder: enable en_hi = X; its outputs drive D[15:8].
- Ideal result when FAULT_EN=0: D[S]=1 and all other bits 0.
- Fault injection when FAULT_EN=1, applied combinationally before the output register:
  - Site 0–15: D[FAULT_SITE] is forced to FAULT_VAL regardless of S.
  - Site 16: en_lo is forced to FAULT_VAL.
  - Site 17: en_hi is forced to FAULT_VAL.
- Default configuration (high enable stuck-at-0): S=0–7 decode normally; S=8–15 give D=0.
- Enable stuck-at-1: the forced half always asserts its line {Y,Z,W}. This can produce two hot bits.
- FAULT_SITE values above 17: treated as no fault.
- fault_flag is computed from the next-D value, not from S: it is 1 if the population count of next-D is not equal to 1, and is registered alongside D.
- Inputs contain no X/Z handling. Inputs are sampled only at the clock edge.

## Timing
- Latency: 1 cycle. D and fault_flag are updated on each rising clk edge from the X/Y/Z/W values present at that edge.
- Reset: when rst=1 at a rising edge, D=16'h0000 and fault_flag=0. Reset overrides any input.
- After rst deasserts, the first edge loads the decode of the current inputs.
- Reset asserted mid-stream: outputs clear at that edge, with no partial state.
- No handshake. Every cycle is valid, and back-to-back input changes each appear one cycle later.
- Input changes between edges have no effect on the outputs.

## Structure
- Shared package dec_fault_pkg holds:
  - the site constants SITE_EN_LO=16 and SITE_EN_HI=17;
  - the width constants SEL_W=4 and OUT_W=16.
- One sub-module, dec_3x8_en: 3-bit select, enable, 8-bit one-hot output, purely combinational. Instantiated twice (low and high halves).
- The top level contains:
  - enable generation;
  - the fault-override mux;
  - the popcount/one-hot check;
  - the output register.

## Test plan
- Reset: hold X=Y=Z=W=0 with rst=1 for 2 cycles -> D=16'h0000, fault_flag=0. Release rst with S=0 -> next cycle D=16'h0001, fault_flag=0.
- Default fault, sweep S=0–15 (one value per cycle): S=0–7 -> D=1<<S, flag=0; S=8–15 -> D=16'h0000, flag=1. Each result appears one cycle after the input is applied.
- FAULT_EN=0, full sweep S=0–15 -> D=1<<S and flag=0 for every code. Example: S=4'b1010 -> D=16'h0400.
- FAULT_SITE=5, FAULT_VAL=1: S=0 -> D=16'h0021, flag=1; S=5 -> D=16'h0020, flag=0.
- FAULT_SITE=16, FAULT_VAL=1: S=4'b1011 -> D=16'h0808, flag=1; S=4'b0011 -> D=16'h0008, flag=0.
- Mid-stream reset: with S=4'b1111 and FAULT_EN=0, assert rst for one cycle -> D=0 at that edge, then D=16'h8000 on the following edge.
